// File: rtl/program_loader_pkg.sv
// Shared definitions for the program-memory download path: loader state
// encodings and the instruction/address width defaults used by PMem and the core.
package program_loader_pkg;

    localparam int unsigned INST_W_DEF = 12;
    localparam int unsigned ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'b00,
        LDR_SHIFT = 2'b01,
        LDR_WRITE = 2'b10,
        LDR_DONE  = 2'b11
    } ldr_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Serial download stream plus PMem load-port bundle; master is the loader,
// slave is the stream source / PMem side.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic              ser_valid;
    logic              ser_bit;
    logic              ser_ready;
    logic              load_e;
    logic [ADDR_W-1:0] load_addr;
    logic [INST_W-1:0] load_inst;
    logic              load_done;
    logic              busy;
    logic              err_ovf;

    modport master (
        input  start, ser_valid, ser_bit,
        output ser_ready, load_e, load_addr, load_inst, load_done, busy, err_ovf
    );

    modport slave (
        output start, ser_valid, ser_bit,
        input  ser_ready, load_e, load_addr, load_inst, load_done, busy, err_ovf
    );
endinterface

// File: rtl/program_loader_bit_deserializer.sv
// MSB-first shift register with bit counter; word_full strobes during the
// cycle in which the W-th bit of a word is being shifted in.
module bit_deserializer #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [W-1:0] word,
    output logic         word_full
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] bit_cnt;

    // Combinational so the loader can enter WRITE on the same edge that takes the last bit
    assign word_full = shift_en && (bit_cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            word    <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            word    <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            word    <= {word[W-2:0], bit_in};
            bit_cnt <= word_full ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// Program loader: assembles serial bits into instructions and writes them
// into PMem one strobe per word, raising load_done after the last word.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned INST_W     = INST_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned PROG_WORDS = 10
) (
    input logic               clk,
    input logic               rst,
    program_loader_if.master  bus
);
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(PROG_WORDS - 1);

    ldr_state_t        state;
    logic [ADDR_W:0]   word_cnt;
    logic [INST_W-1:0] sr_word;
    logic              word_full;
    logic              accept;
    logic              ser_ready_q, load_e_q, load_done_q, busy_q, err_ovf_q;
    logic [ADDR_W-1:0] load_addr_q;
    logic [INST_W-1:0] load_inst_q;

    // ser_ready_q is high exactly in SHIFT, so it doubles as the accept qualifier
    assign accept = bus.ser_valid && ser_ready_q && !bus.start;

    bit_deserializer #(.W(INST_W)) u_deser (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.start),
        .shift_en  (accept),
        .bit_in    (bus.ser_bit),
        .word      (sr_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= LDR_IDLE;
            word_cnt    <= '0;
            ser_ready_q <= 1'b0;
            load_e_q    <= 1'b0;
            load_addr_q <= '0;
            load_inst_q <= '0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else if (bus.start) begin
            // A write in progress this cycle has already been presented to PMem
            state       <= LDR_SHIFT;
            word_cnt    <= '0;
            ser_ready_q <= 1'b1;
            load_e_q    <= 1'b0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b1;
            err_ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                LDR_IDLE: ;
                LDR_SHIFT: begin
                    if (word_full) begin
                        state       <= LDR_WRITE;
                        ser_ready_q <= 1'b0;
                        load_e_q    <= 1'b1;
                        load_addr_q <= word_cnt[ADDR_W-1:0];
                        load_inst_q <= INST_W'({sr_word, bus.ser_bit});
                    end
                end
                LDR_WRITE: begin
                    load_e_q <= 1'b0;
                    word_cnt <= word_cnt + 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        state       <= LDR_DONE;
                        load_addr_q <= '0;
                        load_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        state       <= LDR_SHIFT;
                        ser_ready_q <= 1'b1;
                    end
                end
                LDR_DONE: begin
                    if (bus.ser_valid) err_ovf_q <= 1'b1;
                end
                default: state <= LDR_IDLE;
            endcase
        end
    end

    assign bus.ser_ready = ser_ready_q;
    assign bus.load_e    = load_e_q;
    assign bus.load_addr = load_addr_q;
    assign bus.load_inst = load_inst_q;
    assign bus.load_done = load_done_q;
    assign bus.busy      = busy_q;
    assign bus.err_ovf   = err_ovf_q;
endmodule
